// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction-cache fill controller.
// Geometry is 32 sets of 8-byte lines, two 32-bit instructions per line.
package icache_pkg;

  localparam int CACHE_LINE_BYTES = 8;
  localparam int NUM_SETS         = 32;
  localparam int MEM_TAG_W        = 4;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_LOAD = 2'd1
  } bus_command_t;

  typedef enum logic {
    PF_IDLE   = 1'b0,
    PF_ACTIVE = 1'b1
  } pf_state_t;

  typedef struct packed {
    logic                 valid;
    logic [MEM_TAG_W-1:0] mem_tag;
    logic [31:0]          line_addr;
  } mshr_entry_t;

  function automatic logic [31:0] line_addr(input logic [31:0] a);
    return {a[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/icache_mshr.sv
// Outstanding line-load table: pending lookup for two probe addresses,
// lowest-index free-slot allocation and tag-matched retirement.
module icache_mshr
  import icache_pkg::*;
#(
  parameter int NUM_MSHR = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          probe_a,
  input  logic [31:0]          probe_b,
  output logic                 pending_a,
  output logic                 pending_b,
  output logic                 has_free,
  output logic                 full,
  input  logic                 alloc_en,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  logic [31:0]          alloc_addr,
  input  logic [MEM_TAG_W-1:0] ret_tag,
  output logic                 ret_hit,
  output logic [31:0]          ret_addr
);

  localparam int IDX_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

  mshr_entry_t      entries [NUM_MSHR];
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] ret_idx;

  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    pending_a = 1'b0;
    pending_b = 1'b0;
    has_free  = 1'b0;
    free_idx  = '0;
    ret_hit   = 1'b0;
    ret_idx   = '0;
    ret_addr  = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (entries[i].valid) begin
        if (entries[i].line_addr == probe_a) pending_a = 1'b1;
        if (entries[i].line_addr == probe_b) pending_b = 1'b1;
        if ((ret_tag != '0) && (entries[i].mem_tag == ret_tag)) begin
          ret_hit  = 1'b1;
          ret_idx  = IDX_W'(i);
          ret_addr = entries[i].line_addr;
        end
      end else begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign full = !has_free;

  // A retiring entry is valid and the allocated one was invalid, so they never collide.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (ret_hit) begin
        entries[ret_idx].valid <= 1'b0;
      end
      if (alloc_en && has_free) begin
        entries[free_idx] <= '{valid: 1'b1, mem_tag: alloc_tag, line_addr: alloc_addr};
      end
    end
  end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss/fill controller: demand misses take priority over a
// sequential next-line prefetcher; fills go straight to the cache write port.
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_MSHR = 4,
  parameter int PF_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          fetch_pc,
  input  logic [1:0]           num_valid_instr,
  input  logic                 redirect,
  input  logic                 prefetch_pc_is_in_cache,
  input  logic [MEM_TAG_W-1:0] Imem2proc_response,
  input  logic [63:0]          Imem2proc_data,
  input  logic [MEM_TAG_W-1:0] Imem2proc_tag,
  output logic [1:0]           proc2Imem_command,
  output logic [31:0]          proc2Imem_addr,
  output logic [31:0]          prefetch_pc_check,
  output logic                 write_enable,
  output logic [31:0]          write_addr,
  output logic [63:0]          write_data,
  output logic                 mshr_full
);

  localparam int CNT_W = (PF_DEPTH > 0) ? $clog2(PF_DEPTH + 1) : 1;

  logic [31:0] cur_line;
  logic [31:0] next_line;
  logic [31:0] demand_addr;
  logic        demand_valid;
  logic        demand_want;
  logic        pf_want;
  logic        demand_issue;
  logic        pf_issue;
  logic        issue;
  logic [31:0] issue_addr;
  logic        accepted;

  logic        pend_demand;
  logic        pend_pf;
  logic        has_free;
  logic        full;
  logic        ret_hit;
  logic [31:0] ret_addr;

  pf_state_t   pf_state;
  pf_state_t   pf_state_next;
  logic [31:0] pf_addr;
  logic [31:0] pf_addr_next;
  logic [CNT_W-1:0] pf_cnt;
  logic [CNT_W-1:0] pf_cnt_next;
  logic [31:0] prev_line;
  logic        restart;

  // A one-hit line only misses when the second word lives in the next line.
  always_comb begin
    cur_line     = line_addr(fetch_pc);
    next_line    = line_addr(fetch_pc + 32'd4);
    demand_valid = 1'b0;
    demand_addr  = cur_line;
    case (num_valid_instr)
      2'd0: demand_valid = 1'b1;
      2'd1: begin
        demand_addr  = next_line;
        demand_valid = (next_line != cur_line);
      end
      default: demand_valid = 1'b0;
    endcase
  end

  icache_mshr #(
    .NUM_MSHR (NUM_MSHR)
  ) u_mshr (
    .clock      (clock),
    .reset      (reset),
    .probe_a    (demand_addr),
    .probe_b    (pf_addr),
    .pending_a  (pend_demand),
    .pending_b  (pend_pf),
    .has_free   (has_free),
    .full       (full),
    .alloc_en   (accepted),
    .alloc_tag  (Imem2proc_response),
    .alloc_addr (issue_addr),
    .ret_tag    (Imem2proc_tag),
    .ret_hit    (ret_hit),
    .ret_addr   (ret_addr)
  );

  always_comb begin
    demand_want  = demand_valid && !pend_demand;
    pf_want      = !demand_want && (pf_state == PF_ACTIVE) &&
                   !prefetch_pc_is_in_cache && !pend_pf;
    demand_issue = demand_want && has_free && !reset;
    pf_issue     = pf_want && has_free && !reset;
    issue        = demand_issue || pf_issue;
    issue_addr   = demand_issue ? demand_addr : pf_addr;
    accepted     = issue && (Imem2proc_response != '0);

    proc2Imem_command = issue ? BUS_LOAD : BUS_NONE;
    proc2Imem_addr    = issue ? issue_addr : 32'd0;

    write_enable = ret_hit && !reset;
    write_addr   = write_enable ? ret_addr : 32'd0;
    write_data   = write_enable ? Imem2proc_data : 64'd0;

    mshr_full         = full && !reset;
    prefetch_pc_check = pf_addr;
  end

  // Redirect and a plain line change restart the window identically.
  always_comb begin
    restart       = redirect || (cur_line != prev_line);
    pf_state_next = pf_state;
    pf_addr_next  = pf_addr;
    pf_cnt_next   = pf_cnt;
    if (restart) begin
      pf_state_next = PF_ACTIVE;
      pf_addr_next  = cur_line + 32'd8;
      pf_cnt_next   = '0;
    end else if ((pf_state == PF_ACTIVE) && !demand_issue) begin
      if (prefetch_pc_is_in_cache || pend_pf || (pf_issue && accepted)) begin
        pf_addr_next = pf_addr + 32'd8;
        pf_cnt_next  = pf_cnt + CNT_W'(1);
        if (pf_cnt_next == CNT_W'(PF_DEPTH)) begin
          pf_state_next = PF_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pf_state  <= PF_IDLE;
      pf_addr   <= 32'd0;
      pf_cnt    <= '0;
      prev_line <= 32'd0;
    end else begin
      pf_state  <= pf_state_next;
      pf_addr   <= pf_addr_next;
      pf_cnt    <= pf_cnt_next;
      prev_line <= cur_line;
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: expected loads/fills are queued by the
// stimulus thread and popped by a negedge monitor whenever the DUT drives one.
module tb_icache_fill_ctrl;
  import icache_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [31:0]          fetch_pc;
  logic [1:0]           num_valid_instr;
  logic                 redirect;
  logic                 prefetch_pc_is_in_cache;
  logic [MEM_TAG_W-1:0] Imem2proc_response;
  logic [63:0]          Imem2proc_data;
  logic [MEM_TAG_W-1:0] Imem2proc_tag;
  logic [1:0]           proc2Imem_command;
  logic [31:0]          proc2Imem_addr;
  logic [31:0]          prefetch_pc_check;
  logic                 write_enable;
  logic [31:0]          write_addr;
  logic [63:0]          write_data;
  logic                 mshr_full;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_load_q[$];
  logic [95:0] exp_write_q[$];

  localparam logic [63:0] D1 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D3 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D4 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D5 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D6 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] D7 = 64'h0000_0600_0000_0601;
  localparam logic [63:0] D8 = 64'h0000_0800_0000_0801;
  localparam logic [63:0] D9 = 64'h0000_0500_0000_0501;
  localparam logic [63:0] DA = 64'h0000_0700_0000_0701;
  localparam logic [63:0] DB = 64'h0000_0900_0000_0901;

  always #5 clock = ~clock;

  icache_fill_ctrl #(
    .NUM_MSHR (4),
    .PF_DEPTH (2)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .fetch_pc                (fetch_pc),
    .num_valid_instr         (num_valid_instr),
    .redirect                (redirect),
    .prefetch_pc_is_in_cache (prefetch_pc_is_in_cache),
    .Imem2proc_response      (Imem2proc_response),
    .Imem2proc_data          (Imem2proc_data),
    .Imem2proc_tag           (Imem2proc_tag),
    .proc2Imem_command       (proc2Imem_command),
    .proc2Imem_addr          (proc2Imem_addr),
    .prefetch_pc_check       (prefetch_pc_check),
    .write_enable            (write_enable),
    .write_addr              (write_addr),
    .write_data              (write_data),
    .mshr_full               (mshr_full)
  );

  // Monitor: every load or fill the DUT presents must match the next queued expectation.
  always @(negedge clock) begin
    logic [31:0] el;
    logic [95:0] ew;
    if (proc2Imem_command == 2'(BUS_LOAD)) begin
      checks++;
      if (exp_load_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL load_unexpected got addr=%h expected none", proc2Imem_addr);
      end else begin
        el = exp_load_q.pop_front();
        if (proc2Imem_addr !== el) begin
          errors++;
          $display("[TB] FAIL load_addr got %h expected %h", proc2Imem_addr, el);
        end
      end
    end
    if (write_enable === 1'b1) begin
      checks++;
      if (exp_write_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL fill_unexpected got addr=%h data=%h expected none", write_addr, write_data);
      end else begin
        ew = exp_write_q.pop_front();
        if ({write_addr, write_data} !== ew) begin
          errors++;
          $display("[TB] FAIL fill got addr=%h data=%h expected addr=%h data=%h",
                   write_addr, write_data, ew[95:64], ew[63:0]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic [31:0] pc, input logic [1:0] nvi,
                               input logic redir, input logic in_cache,
                               input logic [3:0] resp, input logic [3:0] rtag,
                               input logic [63:0] rdata);
    @(posedge clock);
    #1;
    reset                   = rst;
    fetch_pc                = pc;
    num_valid_instr         = nvi;
    redirect                = redir;
    prefetch_pc_is_in_cache = in_cache;
    Imem2proc_response      = resp;
    Imem2proc_tag           = rtag;
    Imem2proc_data          = rdata;
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic expectLoad(input logic [31:0] a);
    exp_load_q.push_back(a);
  endtask

  task automatic expectWrite(input logic [31:0] a, input logic [63:0] d);
    exp_write_q.push_back({a, d});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; fetch_pc = '0; num_valid_instr = 2'd2; redirect = 1'b0;
    prefetch_pc_is_in_cache = 1'b1; Imem2proc_response = '0; Imem2proc_tag = '0;
    Imem2proc_data = '0;

    applyStimulus(1, 32'h0, 2, 0, 1, 0, 0, 0);
    applyStimulus(1, 32'h0, 2, 0, 1, 0, 0, 0);
    checkOutput("reset_cmd",     64'(proc2Imem_command), 64'd0);
    checkOutput("reset_addr",    64'(proc2Imem_addr),    64'd0);
    checkOutput("reset_we",      64'(write_enable),      64'd0);
    checkOutput("reset_waddr",   64'(write_addr),        64'd0);
    checkOutput("reset_wdata",   write_data,             64'd0);
    checkOutput("reset_full",    64'(mshr_full),         64'd0);
    checkOutput("reset_pfcheck", 64'(prefetch_pc_check), 64'd0);

    // Cold miss and its fill
    expectLoad(32'h100);
    applyStimulus(0, 32'h100, 0, 0, 1, 3, 0, 0);
    expectWrite(32'h100, D1);
    applyStimulus(0, 32'h100, 0, 0, 1, 0, 3, D1);
    checkOutput("pf_check_after_miss", 64'(prefetch_pc_check), 64'h108);
    applyStimulus(0, 32'h100, 2, 0, 1, 0, 0, 0);

    // Second-word miss crossing into the next line, then a same-line single hit
    expectLoad(32'h108);
    applyStimulus(0, 32'h104, 1, 0, 1, 6, 0, 0);
    expectWrite(32'h108, D2);
    applyStimulus(0, 32'h100, 1, 0, 1, 0, 6, D2);
    checkOutput("no_load_same_line", 64'(proc2Imem_command), 64'd0);

    // Rejections retry every cycle; one acceptance, then no duplicates
    for (int i = 0; i < 3; i++) begin
      expectLoad(32'h200);
      applyStimulus(0, 32'h200, 0, 0, 1, 0, 0, 0);
    end
    expectLoad(32'h200);
    applyStimulus(0, 32'h200, 0, 0, 1, 5, 0, 0);
    applyStimulus(0, 32'h200, 0, 0, 1, 0, 0, 0);
    checkOutput("held_miss_no_reload", 64'(proc2Imem_command), 64'd0);
    applyStimulus(0, 32'h200, 0, 0, 1, 0, 0, 0);
    checkOutput("one_entry_not_full", 64'(mshr_full), 64'd0);
    expectWrite(32'h200, D3);
    applyStimulus(0, 32'h200, 0, 0, 1, 0, 5, D3);
    checkOutput("returning_line_pending", 64'(proc2Imem_command), 64'd0);
    applyStimulus(0, 32'h200, 2, 0, 1, 0, 0, 0);

    // Prefetch window of two lines, including a rejected prefetch that holds
    applyStimulus(0, 32'h300, 2, 0, 0, 0, 0, 0);
    expectLoad(32'h308);
    applyStimulus(0, 32'h300, 2, 0, 0, 7, 0, 0);
    expectLoad(32'h310);
    applyStimulus(0, 32'h300, 2, 0, 0, 0, 0, 0);
    expectLoad(32'h310);
    applyStimulus(0, 32'h300, 2, 0, 0, 8, 0, 0);
    applyStimulus(0, 32'h300, 2, 0, 0, 0, 0, 0);
    checkOutput("pf_window_done", 64'(proc2Imem_command), 64'd0);
    checkOutput("pf_addr_after_window", 64'(prefetch_pc_check), 64'h318);

    // Cached line skipped without a request, next one fetched
    applyStimulus(0, 32'h400, 2, 0, 1, 0, 0, 0);
    applyStimulus(0, 32'h400, 2, 0, 1, 0, 0, 0);
    checkOutput("pf_skip_probe", 64'(prefetch_pc_check), 64'h408);
    checkOutput("pf_skip_no_load", 64'(proc2Imem_command), 64'd0);
    expectLoad(32'h410);
    applyStimulus(0, 32'h400, 2, 0, 0, 9, 0, 0);
    expectWrite(32'h308, D4);
    applyStimulus(0, 32'h400, 2, 0, 1, 0, 7, D4);
    expectWrite(32'h310, D5);
    applyStimulus(0, 32'h400, 2, 0, 1, 0, 8, D5);
    expectWrite(32'h410, D6);
    applyStimulus(0, 32'h400, 2, 0, 1, 0, 9, D6);

    // Fill the table, block a miss, free one slot, reuse it next cycle
    expectLoad(32'h500);
    applyStimulus(0, 32'h500, 0, 0, 1, 1, 0, 0);
    expectLoad(32'h600);
    applyStimulus(0, 32'h600, 0, 0, 1, 2, 0, 0);
    expectLoad(32'h700);
    applyStimulus(0, 32'h700, 0, 0, 1, 3, 0, 0);
    expectLoad(32'h800);
    applyStimulus(0, 32'h800, 0, 0, 1, 4, 0, 0);
    applyStimulus(0, 32'h900, 0, 0, 1, 0, 0, 0);
    checkOutput("full_flag", 64'(mshr_full), 64'd1);
    checkOutput("miss_when_full", 64'(proc2Imem_command), 64'd0);
    expectWrite(32'h600, D7);
    applyStimulus(0, 32'h900, 0, 0, 1, 0, 2, D7);
    checkOutput("no_reuse_same_cycle", 64'(proc2Imem_command), 64'd0);
    checkOutput("full_during_free", 64'(mshr_full), 64'd1);
    expectLoad(32'h900);
    applyStimulus(0, 32'h900, 0, 0, 1, 10, 0, 0);
    checkOutput("not_full_after_free", 64'(mshr_full), 64'd0);
    expectWrite(32'h800, D8);
    applyStimulus(0, 32'h900, 2, 0, 1, 0, 4, D8);
    expectWrite(32'h500, D9);
    applyStimulus(0, 32'h900, 2, 0, 1, 0, 1, D9);
    expectWrite(32'h700, DA);
    applyStimulus(0, 32'h900, 2, 0, 1, 0, 3, DA);
    expectWrite(32'h900, DB);
    applyStimulus(0, 32'h900, 2, 0, 1, 0, 10, DB);
    applyStimulus(0, 32'h900, 2, 0, 1, 0, 12, D1);
    checkOutput("unmatched_tag", 64'(write_enable), 64'd0);

    // Redirect to the top line wraps the prefetch address
    applyStimulus(0, 32'hFFFF_FFF8, 2, 1, 1, 0, 0, 0);
    applyStimulus(0, 32'hFFFF_FFF8, 2, 0, 1, 0, 0, 0);
    checkOutput("pf_wrap", 64'(prefetch_pc_check), 64'h0);

    // Reset with two loads outstanding; late returns must be dropped
    expectLoad(32'hA00);
    applyStimulus(0, 32'hA00, 0, 0, 1, 11, 0, 0);
    expectLoad(32'hB00);
    applyStimulus(0, 32'hB00, 0, 0, 1, 12, 0, 0);
    applyStimulus(1, 32'hC00, 0, 0, 1, 13, 0, 0);
    checkOutput("cmd_in_reset", 64'(proc2Imem_command), 64'd0);
    checkOutput("we_in_reset", 64'(write_enable), 64'd0);
    applyStimulus(0, 32'hB00, 2, 0, 1, 0, 11, D2);
    checkOutput("stale_tag_a", 64'(write_enable), 64'd0);
    checkOutput("full_after_reset", 64'(mshr_full), 64'd0);
    applyStimulus(0, 32'hB00, 2, 0, 1, 0, 12, D3);
    checkOutput("stale_tag_b", 64'(write_enable), 64'd0);
    applyStimulus(0, 32'hB00, 2, 0, 1, 0, 0, 0);

    checkOutput("loads_all_seen", 64'(exp_load_q.size()), 64'd0);
    checkOutput("fills_all_seen", 64'(exp_write_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
Miss/fill controller for the 32-set direct-mapped instruction cache (8-byte lines, two 32-bit instructions per line).
- Detects demand misses from the cache's hit count and issues line loads to instruction memory.
- Tracks outstanding loads by memory tag in a small MSHR table.
- Runs a sequential next-line prefetcher.
- Drives the cache write port when data returns.
- Sits between the fetch stage/cache and the tagged, non-blocking memory interface.

Parameters:
NUM_MSHR, 4, outstanding line loads tracked.
PF_DEPTH, 2, lines ahead of the current fetch line the prefetcher may request.
MEM_TAG_W, 4, memory transaction tag width; tag 0 means "none/rejected".

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
fetch_pc  in  32  current fetch PC (same value the cache sees)
num_valid_instr  in  2  cache hit count for fetch_pc: 0, 1 or 2
redirect  in  1  fetch redirect (branch/flush); restarts prefetch
prefetch_pc_is_in_cache  in  1  cache lookup result for prefetch_pc_check
Imem2proc_response  in  MEM_TAG_W  tag accepted this cycle; 0 = rejected
Imem2proc_data  in  64  returned line data
Imem2proc_tag  in  MEM_TAG_W  tag of returned data; 0 = no data
proc2Imem_command  out  2  BUS_NONE=0, BUS_LOAD=1
proc2Imem_addr  out  32  line-aligned load address ([2:0]=0)
prefetch_pc_check  out  32  line address probed in cache for prefetch
write_enable  out  1  cache fill strobe
write_addr  out  32  fill line address
write_data  out  64  fill data ([31:0] = word 0)
mshr_full  out  1  all MSHR entries valid (status)

Behaviour:
- Line address: line(a) = {a[31:3],3'b0}.

Demand address:
- num_valid_instr==0: demand = line(fetch_pc).
- num_valid_instr==1: demand = line(fetch_pc+4), only when it differs from line(fetch_pc); otherwise no demand.
- num_valid_instr==2: no demand.

MSHR entry: {valid, mem_tag, line_addr}.
- "Pending(x)": some valid entry has line_addr==x.

Request selection each cycle, combinational, priority demand > prefetch:
- Demand: issue if demand exists and !Pending(demand).
- Else prefetch: issue if pf_state==PF_ACTIVE, !prefetch_pc_is_in_cache and !Pending(pf_addr).
- Issue only if a free entry exists, i.e. an entry invalid at the start of the cycle. Entries freed this cycle are not reusable until the next cycle.
- Issue drives proc2Imem_command=BUS_LOAD and proc2Imem_addr. Otherwise BUS_NONE with addr 0.
- Same cycle, Imem2proc_response!=0: allocate the lowest-index free entry at the next edge with that tag.
- Response==0: nothing allocated; retry next cycle.

Fill:
- When Imem2proc_tag!=0 and it matches a valid entry: combinationally write_enable=1, write_addr=entry.line_addr, write_data=Imem2proc_data. The entry is invalidated at the next edge.
- Unmatched non-zero tag: ignored, write_enable=0.
- A line returning this cycle still counts as Pending, so it is not re-requested.
- Fills for lines requested before a redirect still complete; stale fills are harmless.

Prefetch FSM, states PF_IDLE and PF_ACTIVE, registers pf_addr and pf_cnt (0..PF_DEPTH):
- prefetch_pc_check = pf_addr at all times.
- On redirect, or when line(fetch_pc) differs from the registered previous fetch line: pf_addr <= line(fetch_pc)+8, pf_cnt<=0, state<=PF_ACTIVE.
- PF_ACTIVE, with no demand issue this cycle:
  - If the line is in cache, Pending, or a prefetch was accepted: pf_addr+=8, pf_cnt+=1.
  - If a prefetch issue was rejected or no free entry: hold.
- pf_cnt reaching PF_DEPTH: state<=PF_IDLE.
- Address arithmetic wraps modulo 2^32: 0xFFFFFFF8+8 = 0x0.
- Simultaneous redirect and line change: redirect semantics (identical result).

Reset, and reset asserted mid-operation:
- All entries invalid; pf_state=PF_IDLE, pf_addr=0, pf_cnt=0.
- Outputs: command BUS_NONE, addr 0, write_enable 0, write_addr 0, write_data 0, mshr_full 0.
- In-flight memory returns after reset match nothing and are ignored.

Latency:
- Issue happens in the same cycle as the miss.
- Fill happens in the same cycle as the tag return.
- The hit appears the cycle after the fill.

Decomposition:
- Shared package icache_pkg:
  - BUS_NONE/BUS_LOAD command enum.
  - CACHE_LINE_BYTES=8, NUM_SETS=32, MEM_TAG_W.
  - mshr_entry_t struct.
  - line_addr function.
- Sub-module icache_mshr:
  - Entry array.
  - Pending CAM match.
  - Free-entry priority encode.
  - Allocate/free ports.
  - full flag.
- Top level holds request selection and the prefetch FSM.

Test Plan:
- Cold miss: reset, fetch_pc=0x100, num_valid=0, response=3 → LOAD 0x100 same cycle. Return tag=3 data=0xAAAA_BBBB_CCCC_DDDD → write_enable=1, write_addr=0x100; entry freed.
- Second-word miss: fetch_pc=0x104, num_valid=1 → LOAD 0x108. Fetch_pc=0x100, num_valid=1 → no LOAD.
- Rejection/duplicates: response=0 for 3 cycles → LOAD 0x200 repeated each cycle, no allocation. Then response=5 → exactly one entry. The same miss held afterwards issues no further LOAD.
- Prefetch window: PF_DEPTH=2, fetch_pc=0x300 hit → prefetch LOADs 0x308 then 0x310, then PF_IDLE. Cached lines are skipped without a request.
- MSHR full/ordering: 4 loads accepted (tags 1-4), mshr_full=1, new miss → BUS_NONE. Tag 2 return → fill, next cycle new LOAD allocates entry 1. Out-of-order returns 4,1,3 fill correct addresses.
- Redirect/reset: redirect to 0xFFFFFFF8 → prefetch_pc_check=0x0. Reset with 2 entries outstanding, then tag returns → write_enable stays 0.
